// File: rtl/cacheline_adaptor.sv
// ----------------------------------------------------------------------------
// cacheline_adaptor
//
// Bridges a cache controller that moves whole lines (32*WORDS bits) to a
// memory that moves one 32-bit beat per acknowledged cycle.
//
//   IDLE  : wait for read_i (line fill) or write_i (write-back); read wins.
//   READ  : read_o high; each resp_i=1 cycle captures burst_i into the next
//           word of the fill buffer.
//   WRITE : write_o high; burst_o presents the current word of the latched
//           line; each resp_i=1 cycle advances to the next word.
//   DONE  : single-cycle resp_o pulse, then back to IDLE.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   address_i           byte address of the requested line
//   read_i, write_i     fill / write-back requests from the cache controller
//   line_i              write-back line (word k = bits [32k+31:32k])
//   line_o              last completed fill
//   resp_o, err_o       completion pulse, timeout flag (valid with resp_o)
//   address_o           line-aligned memory address (0 while idle)
//   read_o, write_o     memory burst strobes
//   burst_i, burst_o    memory read beat / write beat
//   resp_i              memory beat acknowledge
//
// Optional feature: define CACHELINE_ADAPTOR_TIMEOUT_EN to add a stall
// counter; TIMEOUT_CYCLES consecutive unacknowledged cycles in READ or WRITE
// end the burst through DONE with err_o=1. Without it, err_o is tied low and
// a burst waits indefinitely for its beats.
// ----------------------------------------------------------------------------
module cacheline_adaptor #(
    parameter int WORDS          = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           address_i,
    input  logic                  read_i,
    input  logic                  write_i,
    input  logic [32*WORDS-1:0]   line_i,
    output logic [32*WORDS-1:0]   line_o,
    output logic                  resp_o,
    output logic                  err_o,
    output logic [31:0]           address_o,
    output logic                  read_o,
    output logic                  write_o,
    input  logic [31:0]           burst_i,
    output logic [31:0]           burst_o,
    input  logic                  resp_i
);

    localparam int CNT_W  = $clog2(WORDS);
    localparam int OFFS_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [31:OFFS_W]       addr_reg;
    logic [32*WORDS-1:0]    wline_reg;

    logic                   latch_addr;
    logic                   latch_line;
    logic                   beat;
    logic                   fill_done;

    // The byte offset inside a line never reaches memory.
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^address_i[OFFS_W-1:0];

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

    logic [STALL_W-1:0]     stall_reg;
    logic                   err_reg;
    logic                   timeout_hit;
`else
    // Parameter kept referenced so both builds share one interface.
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        latch_addr = 1'b0;
        latch_line = 1'b0;
        beat       = 1'b0;
        fill_done  = 1'b0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (read_i) begin
                    state_next = READ;
                    latch_addr = 1'b1;
                end else if (write_i) begin
                    state_next = WRITE;
                    latch_addr = 1'b1;
                    latch_line = 1'b1;
                end
            end
            READ, WRITE: begin
                if (resp_i) begin
                    beat = 1'b1;
                    if (cnt_reg == LAST_WORD) begin
                        cnt_next   = '0;
                        state_next = DONE;
                        fill_done  = (state_reg == READ);
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
                else if (stall_reg == STALL_LAST) begin
                    // Abandon the burst; line_o keeps the previous fill.
                    cnt_next    = '0;
                    state_next  = DONE;
                    timeout_hit = 1'b1;
                end
`endif
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counter and request latches
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wline_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (latch_addr) begin
                addr_reg <= address_i[31:OFFS_W];
            end
            if (latch_line) begin
                wline_reg <= line_i;
            end
        end
    end

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    // Counts consecutive unacknowledged cycles of the current burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if ((state_reg == READ || state_reg == WRITE) && !resp_i && !timeout_hit) begin
                stall_reg <= stall_reg + 1'b1;
            end else begin
                stall_reg <= '0;
            end
            // Set on the cycle entering DONE, so it is high only during DONE.
            err_reg <= timeout_hit;
        end
    end

    assign err_o = err_reg;
`else
    assign err_o = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Fill buffer and output line, one slice per word. The final beat is
    // taken straight from burst_i, so it needs no buffer slot; line_o only
    // changes when a whole fill completes.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_word
            logic [31:0] line_word_reg;

            if (gi < WORDS - 1) begin : g_buf
                logic [31:0] fill_word_reg;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        fill_word_reg <= '0;
                    end else if (beat && state_reg == READ && cnt_reg == CNT_W'(gi)) begin
                        fill_word_reg <= burst_i;
                    end
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        line_word_reg <= '0;
                    end else if (fill_done) begin
                        line_word_reg <= fill_word_reg;
                    end
                end
            end else begin : g_last
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        line_word_reg <= '0;
                    end else if (fill_done) begin
                        line_word_reg <= burst_i;
                    end
                end
            end

            assign line_o[32*gi +: 32] = line_word_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs decoded from state; reset forces IDLE, which drives them low.
    // ------------------------------------------------------------------
    assign read_o    = (state_reg == READ);
    assign write_o   = (state_reg == WRITE);
    assign resp_o    = (state_reg == DONE);
    assign address_o = (state_reg == IDLE) ? 32'h0 : {addr_reg, {OFFS_W{1'b0}}};
    assign burst_o   = (state_reg == WRITE) ? wline_reg[{cnt_reg, 5'd0} +: 32] : 32'h0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// ----------------------------------------------------------------------------
// tb_cacheline_adaptor
//
// Scoreboard bench. The stimulus process plays both cache controller and
// memory: for every transaction it predicts the completion (line, address,
// err flag, cycle of the resp_o pulse) and every memory beat, pushing them
// into queues. An independent monitor on the falling edge pops and compares
// whenever the design shows a beat or a completion.
// ----------------------------------------------------------------------------
module tb_cacheline_adaptor;

    localparam int W  = 4;
    localparam int TO = 8;
    localparam int LW = 32 * W;
    localparam logic [31:0] ALIGN_MASK = 32'(W * 4 - 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [31:0]    address_i = '0;
    logic           read_i = 1'b0;
    logic           write_i = 1'b0;
    logic [LW-1:0]  line_i = '0;
    logic [LW-1:0]  line_o;
    logic           resp_o;
    logic           err_o;
    logic [31:0]    address_o;
    logic           read_o;
    logic           write_o;
    logic [31:0]    burst_i = '0;
    logic [31:0]    burst_o;
    logic           resp_i = 1'b0;

    cacheline_adaptor #(
        .WORDS          (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .err_o     (err_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [LW-1:0] line;
        logic [31:0]   addr;
        logic          err;
        int            cyc;
    } resp_t;

    typedef struct {
        bit          wr;
        logic [31:0] data;
        logic [31:0] addr;
    } beat_t;

    resp_t          exp_q[$];
    beat_t          beat_q[$];
    bit             pat_q[$];
    logic [LW-1:0]  model_line = '0;
    int             errors = 0;
    int             checks = 0;
    int             txn_no = 0;

    function automatic void chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int k = 0; k < W; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    // Beat pattern: 'lead' stall cycles, then each beat preceded by 0..max_gap stalls.
    function automatic void make_pattern(int lead, int max_gap);
        pat_q.delete();
        repeat (lead) pat_q.push_back(1'b0);
        for (int k = 0; k < W; k++) begin
            repeat ($urandom_range(max_gap, 0)) pat_q.push_back(1'b0);
            pat_q.push_back(1'b1);
        end
    endfunction

    task automatic check_all_zero(string tag);
        chk({tag, "_line_o"},    line_o,          '0);
        chk({tag, "_address_o"}, LW'(address_o),  '0);
        chk({tag, "_burst_o"},   LW'(burst_o),    '0);
        chk({tag, "_resp_o"},    LW'(resp_o),     '0);
        chk({tag, "_err_o"},     LW'(err_o),      '0);
        chk({tag, "_read_o"},    LW'(read_o),     '0);
        chk({tag, "_write_o"},   LW'(write_o),    '0);
    endtask

    // Runs one transaction using pat_q as the memory acknowledge pattern.
    // Entered and left at posedge+1 with the design in IDLE.
    task automatic run_txn(input bit wr, input bit both, input logic [31:0] addr,
                           input logic [LW-1:0] wline, input logic [LW-1:0] rdata,
                           input bit timeout_case, input int abort_beats);
        resp_t       e;
        beat_t       b;
        int          k;
        bit          is_wr;
        bit          aborted;
        logic [31:0] al;
        is_wr   = wr && !both;
        al      = addr & ~ALIGN_MASK;
        aborted = 1'b0;
        txn_no++;

        e.addr = al;
        e.err  = timeout_case;
        e.cyc  = cyc + pat_q.size() + 1;
        e.line = (is_wr || timeout_case) ? model_line : rdata;
        if (abort_beats < 0) begin
            exp_q.push_back(e);
            if (!is_wr && !timeout_case) model_line = rdata;
        end
        $display("txn %0d: %s addr=%08h cycles=%0d%s%s", txn_no, is_wr ? "write" : "read",
                 addr, pat_q.size(), timeout_case ? " timeout" : "",
                 abort_beats >= 0 ? " reset-abort" : "");

        // Request cycle (design in IDLE); resp_i here must be ignored.
        read_i    = !wr || both;
        write_i   = wr || both;
        address_i = addr;
        line_i    = wline;
        resp_i    = 1'($urandom);
        burst_i   = $urandom;
        @(posedge clk); #1;

        k = 0;
        foreach (pat_q[i]) begin
            // Requests during a burst must be ignored.
            read_i    = 1'($urandom);
            write_i   = 1'($urandom);
            address_i = $urandom;
            line_i    = rand_line();
            resp_i    = pat_q[i];
            burst_i   = $urandom;
            if (pat_q[i]) begin
                if (!is_wr) burst_i = rdata[32*k +: 32];
                b.wr   = is_wr;
                b.data = is_wr ? wline[32*k +: 32] : 32'h0;
                b.addr = al;
                beat_q.push_back(b);
                k++;
            end
            @(posedge clk); #1;
            if (pat_q[i] && k == abort_beats) begin
                aborted = 1'b1;
                break;
            end
        end

        if (aborted) begin
            read_i  = 1'b0;
            write_i = 1'b0;
            resp_i  = 1'b0;
            #1 rst = 1'b1;
            exp_q.delete();
            beat_q.delete();
            #1 check_all_zero("abort_rst");
            model_line = '0;
            @(posedge clk); #1;
            rst = 1'b0;
        end else begin
            // DONE cycle: requests and resp_i must be ignored.
            read_i  = 1'($urandom);
            write_i = 1'($urandom);
            resp_i  = 1'($urandom);
            burst_i = $urandom;
            @(posedge clk); #1;
            read_i  = 1'b0;
            write_i = 1'b0;
            resp_i  = 1'($urandom);
        end
        pat_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares design outputs against the queued predictions.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        resp_t r;
        beat_t b;
        if (!rst) begin
            if (read_o && write_o) chk("strobes_exclusive", LW'({read_o, write_o}), LW'(2'b10));
            if (resp_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp_o", LW'(resp_o), '0);
                end else begin
                    r = exp_q.pop_front();
                    chk("resp_line_o",    line_o,          r.line);
                    chk("resp_address_o", LW'(address_o),  LW'(r.addr));
                    chk("resp_err_o",     LW'(err_o),      LW'(r.err));
                    chk("resp_cycle",     LW'(cyc),        LW'(r.cyc));
                    chk("done_strobes",   LW'({read_o, write_o}), '0);
                end
            end
            if ((read_o || write_o) && resp_i) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", LW'({read_o, write_o}), '0);
                end else begin
                    b = beat_q.pop_front();
                    chk("beat_write_o",   LW'(write_o),   LW'(b.wr));
                    chk("beat_read_o",    LW'(read_o),    LW'(!b.wr));
                    chk("beat_address_o", LW'(address_o), LW'(b.addr));
                    if (b.wr) chk("beat_burst_o", LW'(burst_o), LW'(b.data));
                end
            end else if (write_o && beat_q.size() > 0) begin
                chk("stall_burst_o_hold", LW'(burst_o), LW'(beat_q[0].data));
            end
            if (!read_o && !write_o && !resp_o) chk("idle_address_o", LW'(address_o), '0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] l;
        // Reset is applied before any clock edge: outputs must already be 0.
        #3 check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Read, no stalls, directed data.
        l = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        make_pattern(0, 0);
        run_txn(1'b0, 1'b0, 32'h0000_1234, rand_line(), l, 1'b0, -1);

        // Write with gaps 1,0,1,1,0,1.
        l = {32'h44, 32'h33, 32'h22, 32'h11};
        pat_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_txn(1'b1, 1'b0, 32'h0000_8008, l, rand_line(), 1'b0, -1);

        // Simultaneous read and write: read must win.
        make_pattern(1, 2);
        run_txn(1'b1, 1'b1, 32'hDEAD_BEEF, rand_line(), rand_line(), 1'b0, -1);

        // Reset after the second beat of a read, then a fresh read and a write.
        make_pattern(0, 1);
        run_txn(1'b0, 1'b0, 32'h0000_4440, rand_line(), rand_line(), 1'b0, 2);
        make_pattern(0, 1);
        run_txn(1'b1, 1'b0, 32'h0000_0100, rand_line(), rand_line(), 1'b0, -1);
        make_pattern(0, 0);
        run_txn(1'b0, 1'b0, 32'h0000_4440, rand_line(), rand_line(), 1'b0, -1);

        // Randomized mix.
        for (int n = 0; n < 40; n++) begin
            make_pattern($urandom_range(3, 0), $urandom_range(3, 0));
            run_txn(1'($urandom), ($urandom_range(7, 0) == 0), $urandom,
                    rand_line(), rand_line(), 1'b0, -1);
            repeat ($urandom_range(2, 0)) begin
                resp_i = 1'($urandom);
                @(posedge clk); #1;
            end
        end

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
        // A read that never gets a beat ends after TO stall cycles with err_o.
        pat_q.delete();
        repeat (TO) pat_q.push_back(1'b0);
        run_txn(1'b0, 1'b0, 32'h0000_7770, rand_line(), rand_line(), 1'b1, -1);
        make_pattern(0, 1);
        run_txn(1'b0, 1'b0, 32'h0000_7780, rand_line(), rand_line(), 1'b0, -1);
`else
        // Without the timeout a long stall must not produce a response.
        make_pattern(1000, 0);
        run_txn(1'b0, 1'b0, 32'h0000_7770, rand_line(), rand_line(), 1'b0, -1);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("pending_responses", LW'(exp_q.size()),  '0);
        chk("pending_beats",     LW'(beat_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameter WORDS, 4, 32-bit beats per cache line; SHALL be a power of two, 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, 256, stall-cycle limit; SHALL be used only under CACHELINE_ADAPTOR_TIMEOUT_EN.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 address_i  in  32  byte address of the line requested by the cache controller.
REQ-006 read_i  in  1  line-fill request from the cache controller (its mmem_r).
REQ-007 write_i  in  1  line write-back request from the cache controller.
REQ-008 line_i  in  32*WORDS  write-back line; word k = bits [32k+31:32k].
REQ-009 line_o  out  32*WORDS  filled line.
REQ-010 resp_o  out  1  one-cycle completion pulse to the cache controller (its mmem_status).
REQ-011 err_o  out  1  timeout flag; valid only while resp_o is 1.
REQ-012 address_o  out  32  line-aligned memory address.
REQ-013 read_o, write_o  out  1 each  memory burst read and burst write strobes.
REQ-014 burst_i  in  32  read beat from memory; burst_o  out  32  write beat to memory.
REQ-015 resp_i  in  1  memory beat acknowledge; one beat transfers per cycle with resp_i=1.

Function
REQ-016 States SHALL be IDLE, READ, WRITE and DONE.
REQ-017 In IDLE, read_i=1 SHALL latch address_i and enter READ; read_i SHALL win over write_i when both are 1.
REQ-018 In IDLE, write_i=1 with read_i=0 SHALL latch address_i and line_i, then enter WRITE.
REQ-019 address_o SHALL equal the latched address with the low log2(WORDS)+2 bits forced to 0.
REQ-020 address_o SHALL be 0 in IDLE.
REQ-021 In READ, read_o SHALL be 1; each cycle with resp_i=1 SHALL store burst_i into word[cnt] and increment cnt.
REQ-022 In WRITE, write_o SHALL be 1 and burst_o SHALL equal latched word[cnt]; each cycle with resp_i=1 SHALL increment cnt.
REQ-023 A cycle with resp_i=0 in READ or WRITE SHALL hold cnt, the strobe and burst_o unchanged.
REQ-024 resp_i=1 when cnt=WORDS-1 SHALL enter DONE; cnt SHALL wrap to 0.
REQ-025 DONE SHALL last exactly one cycle with resp_o=1 and read_o=write_o=0, then return to IDLE.
REQ-026 read_i and write_i SHALL be ignored in READ, WRITE and DONE; a request still high in the IDLE after DONE SHALL start a new transaction.
REQ-027 line_o SHALL hold the last completed fill until the next fill completes; write-backs SHALL not change line_o.
REQ-028 resp_i in IDLE or DONE SHALL be ignored.
REQ-029 Minimum latency: request cycle, then WORDS beat cycles, then resp_o in the following cycle.

Reset
REQ-030 rst=1 SHALL force IDLE and cnt=0 immediately, without waiting for a clock edge.
REQ-031 rst=1 SHALL force line_o, address_o, burst_o, resp_o, err_o, read_o and write_o to 0 immediately.
REQ-032 Reset during READ or WRITE SHALL abandon the burst with no resp_o.
REQ-033 After reset deassertion, the first rising edge SHALL evaluate IDLE transitions normally.

Configuration
REQ-034 With CACHELINE_ADAPTOR_TIMEOUT_EN defined, a stall counter SHALL count consecutive resp_i=0 cycles in READ/WRITE and clear on any resp_i=1.
REQ-035 With the macro defined, the counter reaching TIMEOUT_CYCLES SHALL enter DONE with err_o=1, leaving line_o unchanged.
REQ-036 Without the macro, err_o SHALL be constant 0, no stall counter SHALL exist, and stalls SHALL be unbounded.

Verification
REQ-037 Read, no stalls: address_i=0x0000_1234, read_i=1; beats 0xA0,0xA1,0xA2,0xA3 -> address_o=0x0000_1230; line_o word0..3=0xA0..0xA3; resp_o high exactly 1 cycle after the 4th beat.
REQ-038 Write: line_i words 0x11,0x22,0x33,0x44; resp_i toggles 1,0,1,1,0,1 -> burst_o sequence 0x11,0x22,0x33,0x44 held across gaps; write_o low in DONE; line_o unchanged.
REQ-039 Simultaneous read_i=1 and write_i=1 in IDLE -> READ taken, write_o never asserted.
REQ-040 rst pulsed after the 2nd read beat -> all outputs 0 immediately, no resp_o; next read returns a fresh full line.
REQ-041 Macro defined, TIMEOUT_CYCLES=8, resp_i held 0 in READ -> resp_o=1 and err_o=1 after 8 stall cycles; without the macro, no resp_o over 1000 cycles.
